unified_mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the RV32I core's instruction-fetch path and its load/store path.
- Serialises the two requesters through a small FSM, with data given strict priority.
- Generates byte write strobes from the store type, rejects misaligned accesses and times out a hung memory.
- The core's clock-gating/PC-hold logic uses `stall` so the program counter advances only after both accesses for an instruction complete.

---
 rtl/unified_mem_arbiter_if.sv | 41 ++++
 rtl/unified_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - fetch, load/store and unified-memory bus bundle for the memory arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              d_err;

  logic              stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_valid, if_err, d_rdata, d_valid, d_err, stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_valid, if_err, d_rdata, d_valid, d_err, stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - data-priority arbiter sharing one single-port memory between fetch and load/store
module unified_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  unified_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t            r_state;
  logic              r_gnt_d;
  logic [CNT_W-1:0]  r_cnt;

  logic [31:0]       r_if_rdata;
  logic              r_if_valid;
  logic              r_if_err;
  logic [31:0]       r_d_rdata;
  logic              r_d_valid;
  logic              r_d_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_wstrb;

  logic              w_if_mis;
  logic              w_d_mis;
  logic [3:0]        w_strb;
  logic [31:0]       w_wdata;

  always_comb begin
    w_if_mis = (bus.if_addr[1:0] != 2'b00);
    w_d_mis  = 1'b0;
    w_strb   = 4'b0000;
    w_wdata  = bus.d_wdata;
    case (bus.d_size)
      2'b00: begin
        w_strb  = 4'b0001 << bus.d_addr[1:0];
        w_wdata = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        w_d_mis = bus.d_addr[0];
        w_strb  = 4'b0011 << bus.d_addr[1:0];
        w_wdata = {2{bus.d_wdata[15:0]}};
      end
      2'b10: begin
        w_d_mis = (bus.d_addr[1:0] != 2'b00);
        w_strb  = 4'b1111;
      end
      default: w_d_mis = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gnt_d     <= 1'b0;
      r_cnt       <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_if_err    <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
      r_d_err     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Misaligned requests skip the memory and answer straight from IDLE.
          if (!(r_if_valid || r_d_valid)) begin
            if (bus.d_req) begin
              r_gnt_d <= 1'b1;
              if (w_d_mis) begin
                r_state   <= RESP;
                r_d_valid <= 1'b1;
                r_d_err   <= 1'b1;
                r_d_rdata <= '0;
              end else begin
                r_state     <= DATA;
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.d_we;
                r_mem_addr  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
                r_mem_wstrb <= bus.d_we ? w_strb : 4'b0000;
                r_mem_wdata <= bus.d_we ? w_wdata : 32'h0;
              end
            end else if (bus.if_req) begin
              r_gnt_d <= 1'b0;
              if (w_if_mis) begin
                r_state    <= RESP;
                r_if_valid <= 1'b1;
                r_if_err   <= 1'b1;
                r_if_rdata <= '0;
              end else begin
                r_state     <= FETCH;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                r_mem_wstrb <= 4'b0000;
                r_mem_wdata <= 32'h0;
              end
            end
          end
        end
        FETCH, DATA: begin
          if (bus.mem_ready || (r_cnt == CNT_LAST)) begin
            r_state     <= RESP;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= 4'b0000;
            if (r_gnt_d) begin
              r_d_valid <= 1'b1;
              r_d_err   <= !bus.mem_ready;
              r_d_rdata <= (bus.mem_ready && !r_mem_we) ? bus.mem_rdata : 32'h0;
            end else begin
              r_if_valid <= 1'b1;
              r_if_err   <= !bus.mem_ready;
              r_if_rdata <= bus.mem_ready ? bus.mem_rdata : 32'h0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_if_valid <= 1'b0;
          r_if_err   <= 1'b0;
          r_d_valid  <= 1'b0;
          r_d_err    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_err    = r_if_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.d_err     = r_d_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.stall     = ((bus.if_req || bus.d_req) && !(r_if_valid || r_d_valid)) || (r_state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b1;

    // reset
    tick(); tick();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_wstrb", bus.mem_wstrb, 0);
    reset_n = 1;
    tick();

    // fetch only, zero-wait memory
    bus.mem_rdata = 32'h00A00093; bus.if_addr = 32'h10; bus.if_req = 1;
    #1 chk("f_c0_stall", bus.stall, 1);
    tick();
    chk("f_c1_mem_req", bus.mem_req, 1);
    chk("f_c1_addr", bus.mem_addr, 32'h10);
    chk("f_c1_we", bus.mem_we, 0);
    chk("f_c1_if_valid", bus.if_valid, 0);
    tick();
    chk("f_c2_if_valid", bus.if_valid, 1);
    chk("f_c2_if_err", bus.if_err, 0);
    chk("f_c2_if_rdata", bus.if_rdata, 32'h00A00093);
    chk("f_c2_mem_req", bus.mem_req, 0);
    bus.if_req = 0;
    tick();
    chk("f_c3_stall", bus.stall, 0);
    chk("f_c3_if_valid", bus.if_valid, 0);

    // simultaneous fetch and load: data first
    bus.mem_rdata = 32'hCAFEF00D;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h104;
    bus.if_req = 1; bus.if_addr = 32'h20;
    tick();
    chk("b_c1_mem_req", bus.mem_req, 1);
    chk("b_c1_addr", bus.mem_addr, 32'h104);
    chk("b_c1_we", bus.mem_we, 0);
    chk("b_c1_stall", bus.stall, 1);
    tick();
    chk("b_c2_d_valid", bus.d_valid, 1);
    chk("b_c2_if_valid", bus.if_valid, 0);
    chk("b_c2_d_rdata", bus.d_rdata, 32'hCAFEF00D);
    chk("b_c2_stall", bus.stall, 1);
    bus.d_req = 0;
    tick();
    chk("b_c3_stall", bus.stall, 1);
    chk("b_c3_mem_req", bus.mem_req, 0);
    bus.mem_rdata = 32'h12345678;
    tick();
    chk("b_c4_mem_req", bus.mem_req, 1);
    chk("b_c4_addr", bus.mem_addr, 32'h20);
    chk("b_c4_stall", bus.stall, 1);
    tick();
    chk("b_c5_if_valid", bus.if_valid, 1);
    chk("b_c5_d_valid", bus.d_valid, 0);
    chk("b_c5_if_rdata", bus.if_rdata, 32'h12345678);
    bus.if_req = 0;
    tick();
    chk("b_c6_stall", bus.stall, 0);

    // timeout with TIMEOUT_CYCLES=4
    bus.mem_ready = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h300;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t_c%0d_mem_req", i), bus.mem_req, 1);
      chk($sformatf("t_c%0d_d_valid", i), bus.d_valid, 0);
    end
    tick();
    chk("t_c5_mem_req", bus.mem_req, 0);
    chk("t_c5_d_valid", bus.d_valid, 1);
    chk("t_c5_d_err", bus.d_err, 1);
    chk("t_c5_d_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    tick();
    chk("t_c6_stall", bus.stall, 0);
    chk("t_c6_d_valid", bus.d_valid, 0);

    // stores with lane replication
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF; bus.d_wdata = 32'h11223344; bus.d_we = 1;
    bus.d_req = 1; bus.d_size = 2'b00; bus.d_addr = 32'h203;
    tick();
    chk("sb_we", bus.mem_we, 1);
    chk("sb_addr", bus.mem_addr, 32'h200);
    chk("sb_wstrb", bus.mem_wstrb, 4'b1000);
    chk("sb_wdata", bus.mem_wdata, 32'h44444444);
    tick();
    chk("sb_d_valid", bus.d_valid, 1);
    chk("sb_d_err", bus.d_err, 0);
    bus.d_req = 0;
    tick();
    bus.d_req = 1; bus.d_size = 2'b01; bus.d_addr = 32'h202;
    tick();
    chk("sh_wstrb", bus.mem_wstrb, 4'b1100);
    chk("sh_wdata", bus.mem_wdata, 32'h33443344);
    tick();
    chk("sh_d_valid", bus.d_valid, 1);
    bus.d_req = 0;
    tick();
    bus.d_req = 1; bus.d_size = 2'b10; bus.d_addr = 32'h200;
    tick();
    chk("sw_wstrb", bus.mem_wstrb, 4'b1111);
    chk("sw_wdata", bus.mem_wdata, 32'h11223344);
    tick();
    chk("sw_d_valid", bus.d_valid, 1);
    chk("sw_d_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    tick();

    // misaligned half store and fetch
    bus.d_req = 1; bus.d_size = 2'b01; bus.d_addr = 32'h201;
    tick();
    chk("mh_mem_req", bus.mem_req, 0);
    chk("mh_d_valid", bus.d_valid, 1);
    chk("mh_d_err", bus.d_err, 1);
    bus.d_req = 0; bus.d_we = 0;
    tick();
    bus.if_req = 1; bus.if_addr = 32'h6;
    tick();
    chk("mf_mem_req", bus.mem_req, 0);
    chk("mf_if_valid", bus.if_valid, 1);
    chk("mf_if_err", bus.if_err, 1);
    chk("mf_if_rdata", bus.if_rdata, 0);
    bus.if_req = 0;
    tick();
    chk("mf_stall", bus.stall, 0);

    // reset during second wait state, then retry
    bus.mem_ready = 0; bus.mem_rdata = 32'h0BADCAFE;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'b10; bus.d_addr = 32'h400;
    tick();
    chk("r_c1_mem_req", bus.mem_req, 1);
    tick();
    reset_n = 0;
    tick();
    chk("r_c3_mem_req", bus.mem_req, 0);
    chk("r_c3_d_valid", bus.d_valid, 0);
    chk("r_c3_stall", bus.stall, 1);
    reset_n = 1;
    tick();
    chk("r_c4_mem_req", bus.mem_req, 1);
    chk("r_c4_addr", bus.mem_addr, 32'h400);
    tick();
    chk("r_c5_d_valid", bus.d_valid, 0);
    tick();
    chk("r_c6_mem_req", bus.mem_req, 1);
    bus.mem_ready = 1;
    tick();
    chk("r_c7_d_valid", bus.d_valid, 1);
    chk("r_c7_d_err", bus.d_err, 0);
    chk("r_c7_d_rdata", bus.d_rdata, 32'h0BADCAFE);
    bus.d_req = 0;
    tick();
    chk("r_c8_stall", bus.stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
